// File: rtl/io_memory_dumper_pkg.sv
// ----------------------------------------------------------------------------
// io_memory_dumper_pkg
// Shared SystemControl definitions for the memory read-back (dump) path:
//   - dump_state_t : dumper FSM state encoding
//   - MEMWORDS     : words per memory (10-bit word address space)
//   - ADDR_LSB / DATA_LSB : field offsets inside the 32-bit IOOut_Data word
//   - pack_io_word : builds {6'b0, address, data} from its fields
// ----------------------------------------------------------------------------
package io_memory_dumper_pkg;

    localparam int DUMP_AW  = 10;
    localparam int DUMP_DW  = 16;
    localparam int IO_W     = 32;
    localparam int MEMWORDS = 1024;
    localparam int ADDR_LSB = 16;
    localparam int DATA_LSB = 0;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_READ    = 3'd1,
        ST_CAPTURE = 3'd2,
        ST_SEND    = 3'd3,
        ST_DONE    = 3'd4
    } dump_state_t;

    // Unused upper bits of the IO word stay zero.
    function automatic logic [IO_W-1:0] pack_io_word(
        input logic [DUMP_AW-1:0] addr,
        input logic [DUMP_DW-1:0] data
    );
        logic [IO_W-1:0] w;
        w = '0;
        w[ADDR_LSB +: DUMP_AW] = addr;
        w[DATA_LSB +: DUMP_DW] = data;
        return w;
    endfunction

endpackage

// File: rtl/io_memory_dumper_sender.sv
// ----------------------------------------------------------------------------
// io_memory_dumper_sender
// Output holding register and REQ/ACK handshake for the IO output channel.
// A load captures {address, data} and raises REQ; REQ and the word then hold
// until the sink acknowledges, at which point o_xfer pulses for that cycle.
//
// Ports:
//   clk, clk_en, sync_rst : clock, clock enable, synchronous active-high reset
//   i_load                : capture i_addr/i_data and raise REQ
//   i_addr, i_data        : word address and memory data to send
//   i_ack                 : sink accepts (ignored while REQ is low)
//   o_req                 : output word valid
//   o_data                : packed output word {6'b0, addr, data}
//   o_xfer                : transfer happens on this enabled cycle
// ----------------------------------------------------------------------------
module io_memory_dumper_sender
    import io_memory_dumper_pkg::*;
(
    input  logic               clk,
    input  logic               clk_en,
    input  logic               sync_rst,
    input  logic               i_load,
    input  logic [DUMP_AW-1:0] i_addr,
    input  logic [DUMP_DW-1:0] i_data,
    input  logic               i_ack,
    output logic               o_req,
    output logic [IO_W-1:0]    o_data,
    output logic               o_xfer
);

    logic            r_req;
    logic [IO_W-1:0] r_data;
    logic            w_xfer;

    // A transfer only counts on an enabled cycle, so a stalled clock never
    // consumes a word.
    assign w_xfer = r_req & i_ack & clk_en;

    always_ff @(posedge clk) begin
        if (sync_rst) begin
            r_req  <= 1'b0;
            r_data <= '0;
        end else if (clk_en) begin
            if (i_load) begin
                r_req  <= 1'b1;
                r_data <= pack_io_word(i_addr, i_data);
            end else if (w_xfer) begin
                r_req  <= 1'b0;
            end
        end
    end

    assign o_req  = r_req;
    assign o_data = r_data;
    assign o_xfer = w_xfer;

endmodule

// File: rtl/io_memory_dumper.sv
// ----------------------------------------------------------------------------
// io_memory_dumper
// Read-back engine for the memory-flash path. On DumpInit it reads a
// contiguous range of instruction or data memory one word at a time and
// streams {address, data} words to the IO output channel, keeping a running
// 16-bit wrapping checksum of every word read.
//
// Ports:
//   clk, clk_en, sync_rst          : clock, clock enable, sync active-high reset
//   DumpInit                       : start pulse (ignored while busy)
//   DumpSource                     : 0 = instruction memory, 1 = data memory
//   DumpStartAddr, DumpLength      : first word address, word count (0..1024)
//   InstReadEn, DataReadEn         : memory read strobes (one per word)
//   MemReadAddr                    : memory read address
//   InstReadData, DataReadData     : read data, valid one cycle after strobe
//   IOOut_REQ, IOOut_ACK           : output channel handshake
//   IOOut_Data                     : {6'b0, address[9:0], data[15:0]}
//   DumpBusy, DumpDone             : busy level, one-cycle completion pulse
//   DumpChecksum                   : wrapping sum of dumped words
// ----------------------------------------------------------------------------
module io_memory_dumper
    import io_memory_dumper_pkg::*;
#(
    parameter int ADDRWIDTH = 10,
    parameter int DATAWIDTH = 16
) (
    input  logic                 clk,
    input  logic                 clk_en,
    input  logic                 sync_rst,
    input  logic                 DumpInit,
    input  logic                 DumpSource,
    input  logic [ADDRWIDTH-1:0] DumpStartAddr,
    input  logic [ADDRWIDTH:0]   DumpLength,
    output logic                 InstReadEn,
    output logic                 DataReadEn,
    output logic [ADDRWIDTH-1:0] MemReadAddr,
    input  logic [DATAWIDTH-1:0] InstReadData,
    input  logic [DATAWIDTH-1:0] DataReadData,
    output logic                 IOOut_REQ,
    input  logic                 IOOut_ACK,
    output logic [31:0]          IOOut_Data,
    output logic                 DumpBusy,
    output logic                 DumpDone,
    output logic [DATAWIDTH-1:0] DumpChecksum
);

    dump_state_t          r_state;
    dump_state_t          w_next_state;
    logic                 r_src;
    logic [ADDRWIDTH-1:0] r_addr;
    logic [ADDRWIDTH:0]   r_remaining;
    logic [DATAWIDTH-1:0] r_checksum;

    logic                 w_start;
    logic                 w_last;
    logic                 w_load;
    logic                 w_xfer;
    logic [DATAWIDTH-1:0] w_rdata;

    assign w_start = (r_state == ST_IDLE) && DumpInit;
    assign w_load  = (r_state == ST_CAPTURE);
    assign w_last  = (r_remaining == (ADDRWIDTH+1)'(1));
    assign w_rdata = r_src ? DataReadData : InstReadData;

    // State register
    always_ff @(posedge clk) begin
        if (sync_rst) begin
            r_state <= ST_IDLE;
        end else if (clk_en) begin
            r_state <= w_next_state;
        end
    end

    // Next-state logic
    always_comb begin
        w_next_state = r_state;
        unique case (r_state)
            ST_IDLE:    if (DumpInit) w_next_state = (DumpLength == '0) ? ST_DONE : ST_READ;
            ST_READ:    w_next_state = ST_CAPTURE;
            ST_CAPTURE: w_next_state = ST_SEND;
            ST_SEND:    if (w_xfer) w_next_state = w_last ? ST_DONE : ST_READ;
            ST_DONE:    w_next_state = ST_IDLE;
            default:    w_next_state = ST_IDLE;
        endcase
    end

    // State-decoded outputs
    always_comb begin
        InstReadEn = (r_state == ST_READ) && !r_src;
        DataReadEn = (r_state == ST_READ) &&  r_src;
        DumpBusy   = (r_state != ST_IDLE);
        DumpDone   = (r_state == ST_DONE);
    end

    // Dump parameters, address/count progression and checksum. The address
    // register wraps naturally at the top of memory.
    always_ff @(posedge clk) begin
        if (sync_rst) begin
            r_src       <= 1'b0;
            r_addr      <= '0;
            r_remaining <= '0;
            r_checksum  <= '0;
        end else if (clk_en) begin
            if (w_start) begin
                r_src       <= DumpSource;
                r_addr      <= DumpStartAddr;
                r_remaining <= DumpLength;
                r_checksum  <= '0;
            end
            if (r_state == ST_CAPTURE) begin
                r_checksum <= r_checksum + w_rdata;
            end
            if ((r_state == ST_SEND) && w_xfer) begin
                r_remaining <= r_remaining - 1'b1;
                r_addr      <= r_addr + 1'b1;
            end
        end
    end

    assign MemReadAddr  = r_addr;
    assign DumpChecksum = r_checksum;

    io_memory_dumper_sender u_sender (
        .clk      (clk),
        .clk_en   (clk_en),
        .sync_rst (sync_rst),
        .i_load   (w_load),
        .i_addr   (r_addr),
        .i_data   (w_rdata),
        .i_ack    (IOOut_ACK),
        .o_req    (IOOut_REQ),
        .o_data   (IOOut_Data),
        .o_xfer   (w_xfer)
    );

endmodule

// File: tb/tb_io_memory_dumper.sv
// ----------------------------------------------------------------------------
// tb_io_memory_dumper
// Directed bench for io_memory_dumper with behavioural instruction/data
// memories (1-cycle read latency) and an IO sink whose ACK and the clock
// enable can be held high or randomised.
// ----------------------------------------------------------------------------
module tb_io_memory_dumper;

    logic        clk           = 1'b0;
    logic        clk_en        = 1'b1;
    logic        sync_rst      = 1'b1;
    logic        DumpInit      = 1'b0;
    logic        DumpSource    = 1'b0;
    logic [9:0]  DumpStartAddr = '0;
    logic [10:0] DumpLength    = '0;
    logic        InstReadEn;
    logic        DataReadEn;
    logic [9:0]  MemReadAddr;
    logic [15:0] InstReadData  = '0;
    logic [15:0] DataReadData  = '0;
    logic        IOOut_REQ;
    logic        IOOut_ACK     = 1'b1;
    logic [31:0] IOOut_Data;
    logic        DumpBusy;
    logic        DumpDone;
    logic [15:0] DumpChecksum;

    io_memory_dumper dut (
        .clk           (clk),
        .clk_en        (clk_en),
        .sync_rst      (sync_rst),
        .DumpInit      (DumpInit),
        .DumpSource    (DumpSource),
        .DumpStartAddr (DumpStartAddr),
        .DumpLength    (DumpLength),
        .InstReadEn    (InstReadEn),
        .DataReadEn    (DataReadEn),
        .MemReadAddr   (MemReadAddr),
        .InstReadData  (InstReadData),
        .DataReadData  (DataReadData),
        .IOOut_REQ     (IOOut_REQ),
        .IOOut_ACK     (IOOut_ACK),
        .IOOut_Data    (IOOut_Data),
        .DumpBusy      (DumpBusy),
        .DumpDone      (DumpDone),
        .DumpChecksum  (DumpChecksum)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;
    int cyc   = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // Memory contents: instruction word = 0x1000 + 3*a, data word = 0x8000 ^ 37*a
    function automatic logic [15:0] mem_word(input logic src, input logic [9:0] a);
        logic [15:0] t;
        t = {6'd0, a};
        return src ? (16'h8000 ^ (t * 16'd37)) : (16'h1000 + t * 16'd3);
    endfunction

    always @(posedge clk) begin
        if (clk_en) begin
            if (InstReadEn) InstReadData <= mem_word(1'b0, MemReadAddr);
            if (DataReadEn) DataReadData <= mem_word(1'b1, MemReadAddr);
        end
    end

    // Sink / clock-enable driver: 0 = ACK low, 1 = ACK high, 2 = random ACK
    int ack_mode = 1;
    bit cen_rand = 1'b0;

    always @(posedge clk) begin
        #1;
        IOOut_ACK = (ack_mode == 2) ? ($urandom_range(0, 2) != 0) : (ack_mode == 1);
        clk_en    = cen_rand ? ($urandom_range(0, 3) != 0) : 1'b1;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Observation of transfers, strobes and key event cycles (relative to t0)
    logic [31:0] xq[$];
    int          t0        = 0;
    int          first_rd  = -1;
    int          first_req = -1;
    int          done_cyc  = -1;
    int          n_inst    = 0;
    int          n_data    = 0;
    logic        prev_req  = 1'b0;
    logic        prev_xfer = 1'b0;
    logic        prev_rst  = 1'b1;
    logic [31:0] prev_data = '0;

    always @(negedge clk) begin
        if (prev_req && !prev_xfer && !prev_rst) begin
            tests++;
            assert (IOOut_REQ === 1'b1 && IOOut_Data === prev_data) else begin
                fails++;
                $error("FAIL hold: observed req=%0b data=%0h expected req=1 data=%0h",
                       IOOut_REQ, IOOut_Data, prev_data);
            end
        end
        if (clk_en && !sync_rst) begin
            if (InstReadEn) n_inst++;
            if (DataReadEn) n_data++;
            if ((InstReadEn || DataReadEn) && first_rd < 0) first_rd = cyc - t0;
            if (IOOut_REQ && first_req < 0) first_req = cyc - t0;
            if (DumpDone && done_cyc < 0) done_cyc = cyc - t0;
            if (IOOut_REQ && IOOut_ACK) xq.push_back(IOOut_Data);
        end
        prev_req  = IOOut_REQ;
        prev_xfer = IOOut_REQ && IOOut_ACK && clk_en && !sync_rst;
        prev_rst  = sync_rst;
        prev_data = IOOut_Data;
    end

    task automatic start_dump(input logic src, input logic [9:0] a, input logic [10:0] len);
        @(posedge clk); #1;
        xq.delete();
        first_rd  = -1;
        first_req = -1;
        done_cyc  = -1;
        n_inst    = 0;
        n_data    = 0;
        DumpSource    = src;
        DumpStartAddr = a;
        DumpLength    = len;
        DumpInit      = 1'b1;
        t0            = cyc;
        @(posedge clk); #1;
        DumpInit = 1'b0;
    endtask

    task automatic wait_done(input int limit, input string tag);
        for (int k = 0; k < limit; k++) begin
            @(negedge clk); #1;
            if (done_cyc >= 0) break;
        end
        tests++;
        assert (done_cyc >= 0) else begin
            fails++;
            $error("FAIL %s_timeout: observed no DumpDone expected DumpDone within %0d cycles", tag, limit);
        end
    endtask

    task automatic check_words(input string tag, input logic src, input logic [9:0] start, input int len);
        logic [9:0]  a;
        logic [15:0] sum;
        sum = '0;
        check({tag, "_count"}, 32'(xq.size()), 32'(len));
        for (int i = 0; i < len; i++) begin
            a   = start + 10'(i);
            sum = sum + mem_word(src, a);
            if (i < xq.size())
                check($sformatf("%s_word%0d", tag, i), xq[i], {6'd0, a, mem_word(src, a)});
        end
        check({tag, "_checksum"}, 32'(DumpChecksum), 32'(sum));
    endtask

    initial begin
        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check("rst_req",    32'(IOOut_REQ),    32'd0);
        check("rst_busy",   32'(DumpBusy),     32'd0);
        check("rst_done",   32'(DumpDone),     32'd0);
        check("rst_data",   IOOut_Data,        32'd0);
        check("rst_addr",   32'(MemReadAddr),  32'd0);
        check("rst_csum",   32'(DumpChecksum), 32'd0);
        check("rst_rden",   32'({InstReadEn, DataReadEn}), 32'd0);
        sync_rst = 1'b0;
        repeat (2) @(posedge clk);

        // Instruction dump 0x010, length 4, ACK high
        start_dump(1'b0, 10'h010, 11'd4);
        check("t1_busy_c1",  32'(DumpBusy),    32'd1);
        check("t1_iren_c1",  32'(InstReadEn),  32'd1);
        check("t1_raddr_c1", 32'(MemReadAddr), 32'h010);
        wait_done(40, "t1");
        check("t1_first_rd",  32'(first_rd),  32'd1);
        check("t1_first_req", 32'(first_req), 32'd3);
        check("t1_done_cyc",  32'(done_cyc),  32'd13);
        check("t1_n_inst",    32'(n_inst),    32'd4);
        check("t1_n_data",    32'(n_data),    32'd0);
        check("t1_csum_hand", 32'(DumpChecksum), 32'h40D2);
        if (xq.size() > 0) check("t1_word0_hand", xq[0], 32'h0010_1030);
        check_words("t1", 1'b0, 10'h010, 4);
        @(negedge clk);
        check("t1_idle_busy", 32'(DumpBusy), 32'd0);

        // Data dump 0x3FE, length 3, address wraps to 0
        start_dump(1'b1, 10'h3FE, 11'd3);
        wait_done(40, "t2");
        check("t2_done_cyc",  32'(done_cyc), 32'd10);
        check("t2_n_inst",    32'(n_inst),   32'd0);
        check("t2_n_data",    32'(n_data),   32'd3);
        check("t2_csum_hand", 32'(DumpChecksum), 32'hA791);
        if (xq.size() > 2) check("t2_word2_hand", xq[2], 32'h0000_8000);
        check_words("t2", 1'b1, 10'h3FE, 3);

        // Random ACK backpressure and clock-enable gaps
        start_dump(1'b0, 10'h100, 11'd20);
        ack_mode = 2;
        cen_rand = 1'b1;
        wait_done(2000, "t3");
        ack_mode = 1;
        cen_rand = 1'b0;
        check("t3_n_inst", 32'(n_inst), 32'd20);
        check_words("t3", 1'b0, 10'h100, 20);

        // Length 0
        start_dump(1'b1, 10'h123, 11'd0);
        wait_done(10, "t4");
        check("t4_done_cyc",  32'(done_cyc),  32'd1);
        check("t4_no_req",    32'(first_req), 32'hFFFF_FFFF);
        check("t4_no_read",   32'(n_inst + n_data), 32'd0);
        check("t4_csum",      32'(DumpChecksum), 32'd0);
        check("t4_count",     32'(xq.size()), 32'd0);

        // DumpInit re-pulsed mid-dump is ignored
        start_dump(1'b1, 10'h050, 11'd5);
        repeat (3) @(posedge clk);
        #1;
        DumpSource    = 1'b0;
        DumpStartAddr = 10'h300;
        DumpLength    = 11'd2;
        DumpInit      = 1'b1;
        @(posedge clk); #1;
        DumpInit = 1'b0;
        wait_done(60, "t5");
        check("t5_done_cyc", 32'(done_cyc), 32'd16);
        check("t5_n_inst",   32'(n_inst),   32'd0);
        check("t5_n_data",   32'(n_data),   32'd5);
        check_words("t5", 1'b1, 10'h050, 5);

        // Full memory from 0x200 with wrap
        start_dump(1'b0, 10'h200, 11'd1024);
        wait_done(3200, "t6");
        check("t6_done_cyc", 32'(done_cyc), 32'd3073);
        check("t6_n_inst",   32'(n_inst),   32'd1024);
        check_words("t6", 1'b0, 10'h200, 1024);

        // Reset while waiting in SEND
        ack_mode = 0;
        start_dump(1'b0, 10'h020, 11'd4);
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (IOOut_REQ) break;
        end
        check("t7_req_before", 32'(IOOut_REQ), 32'd1);
        @(posedge clk); #1;
        sync_rst = 1'b1;
        @(posedge clk); #1;
        sync_rst = 1'b0;
        check("t7_req",  32'(IOOut_REQ),    32'd0);
        check("t7_busy", 32'(DumpBusy),     32'd0);
        check("t7_csum", 32'(DumpChecksum), 32'd0);
        check("t7_data", IOOut_Data,        32'd0);
        check("t7_addr", 32'(MemReadAddr),  32'd0);
        ack_mode = 1;
        repeat (5) @(negedge clk);
        check("t7_no_emit", 32'(xq.size()), 32'd0);
        start_dump(1'b1, 10'h001, 11'd2);
        wait_done(40, "t7b");
        check("t7b_done_cyc", 32'(done_cyc), 32'd7);
        check_words("t7b", 1'b1, 10'h001, 2);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: observed simulation still running expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/io_memory_dumper.md
# io_memory_dumper

Read-back engine for the memory-flash path: on command it reads a contiguous range of instruction or data memory through the memory read ports, one 16-bit word at a time, and streams each word with its address to the IO output channel over a REQ/ACK handshake. It keeps a running 16-bit checksum so software can verify a completed flash. It sits beside the flasher in SystemControl and uses the same 10-bit address and 16-bit data memory geometry, read instead of written.

## Interface
- ADDRWIDTH, 10, memory word-address width
- DATAWIDTH, 16, memory word width
- clk  in  1  system clock
- clk_en  in  1  clock enable; when low, all state and outputs hold
- sync_rst  in  1  reset, synchronous, active-high
- DumpInit  in  1  start pulse; ignored while DumpBusy
- DumpSource  in  1  0 = instruction memory, 1 = data memory; sampled with DumpInit
- DumpStartAddr  in  10  first word address; sampled with DumpInit
- DumpLength  in  11  word count, 0..1024; sampled with DumpInit
- InstReadEn  out  1  instruction-memory read strobe
- DataReadEn  out  1  data-memory read strobe
- MemReadAddr  out  10  read address
- InstReadData  in  16  instruction-memory data, valid 1 cycle after InstReadEn
- DataReadData  in  16  data-memory data, valid 1 cycle after DataReadEn
- IOOut_REQ  out  1  output word valid
- IOOut_ACK  in  1  sink accepts
- IOOut_Data  out  32  {6'b0, address[9:0], data[15:0]}
- DumpBusy  out  1  high from the cycle after accepted DumpInit until DONE
- DumpDone  out  1  one-cycle completion pulse
- DumpChecksum  out  16  running wrapping sum of dumped words

## Operation
- States: IDLE, READ, CAPTURE, SEND, DONE.
- IDLE: on DumpInit, latch source, address, and length. Clear checksum. If length = 0, go to DONE; otherwise go to READ.
- READ: assert the read enable of the selected memory (exactly one of InstReadEn/DataReadEn) with MemReadAddr = current address. Go to CAPTURE.
- CAPTURE: register the selected read data into the output holding register with the current address. Checksum += data, modulo 2^16. Go to SEND.
- SEND: IOOut_REQ = 1. IOOut_Data is stable until transfer. A transfer occurs on a cycle with REQ && ACK. On transfer: decrement the remaining count and increment the address modulo 1024 (1023 wraps to 0). If the remaining count becomes 0, go to DONE; otherwise go to READ. ACK without REQ is ignored.
- DONE: DumpDone = 1 for one cycle, then IDLE. The checksum holds until the next accepted DumpInit.
- DumpInit while busy is ignored. No abort; sync_rst is the only abort.
- Reset (including mid-dump): state IDLE; REQ, read enables, DumpBusy, and DumpDone are 0; IOOut_Data is 0; MemReadAddr is 0; checksum is 0. Nothing is emitted after reset.

## Timing
- All transitions are gated by clk_en; a stalled clk_en never drops REQ or alters IOOut_Data.
- DumpInit sampled at cycle 0: read strobe at cycle 1, REQ at cycle 3.
- With ACK held high, each word takes 3 cycles (READ, CAPTURE, SEND). A length-N dump finishes with DumpDone at cycle 3N+1.
- Memory read latency is a fixed 1 cycle; the read enable is single-cycle per word.
- DumpBusy = (state != IDLE).

## Structure
- The shared SystemControl package holds the dumper state enum, MEMWORDS = 1024, and the IOOut_Data field offsets (ADDR_LSB = 16, DATA_LSB = 0).
- One sub-module: io_memory_dumper_sender, the holding register plus REQ/ACK logic (load, hold-until-ACK, transfer pulse). The FSM, counters, and checksum stay in the top level.

## Test plan
- Inst dump, start 0x010, length 4, ACK tied high: 4 words with addresses 0x010..0x013 and matching memory data; DumpDone at cycle 13; checksum = sum of the 4 words.
- Data dump, start 0x3FE, length 3: addresses 0x3FE, 0x3FF, then 0x000; only DataReadEn pulses.
- Random ACK backpressure plus random clk_en gaps: IOOut_Data is stable while REQ is high; no word is lost or duplicated.
- Length 0: DumpDone at cycle 1, REQ never asserts, checksum = 0.
- DumpInit re-pulsed mid-dump with different parameters: ignored, the original dump completes unchanged. Length 1024 from 0x200 covers all of memory with a wrap.
- sync_rst asserted in SEND: next cycle REQ = 0, DumpBusy = 0, checksum = 0. A new DumpInit after reset runs normally.
